// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler
//
// Shares the SPI slave transmit shift path among NUM_REQ on-chip requesters.
// Round-robin picks one pending 32-bit word, holds it on the sender's parallel
// load port for LOAD_CYCLES clocks, then waits for the sender's word-complete
// flag (synchronised from the sck domain) before acknowledging the requester.
// If chip select is released mid-word, the word is abandoned without an ack
// and the same requester is offered first again.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   req_valid_i  per-requester word pending, held until its ack
//   req_data_i   packed words, requester i at [32*i+31:32*i]
//   req_ack_o    one-cycle pulse, word of requester grant_o fully shifted
//   scs_i        SPI chip select from pad, active-low, asynchronous
//   tx_data_o    word for the sender's parallel input
//   tx_valid_o   load request to the sender
//   tx_done_i    sender word-complete flag, sck domain
//   busy_o       scheduler is not idle
//   grant_o      index of current or last granted requester
//   abort_o      one-cycle pulse, word abandoned on chip select release

module spi_tx_scheduler #(
  parameter int unsigned NUM_REQ     = 2,  // 1..8
  parameter int unsigned LOAD_CYCLES = 8   // 1..16, longer than one sck period + 2 clk
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [32*NUM_REQ-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]     req_ack_o,
  input  logic                   scs_i,
  output logic [31:0]            tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_done_i,
  output logic                   busy_o,
  output logic [2:0]             grant_o,
  output logic                   abort_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  state_e       state_q;
  logic         scs_meta_q, scs_s_q;
  logic         done_meta_q, done_s_q, done_q;
  logic         done_rise;
  logic [2:0]   rr_ptr_q;
  logic [3:0]   load_cnt_q;

  logic               arb_found;
  logic [2:0]         arb_idx;
  logic [31:0]        arb_data;
  logic [3:0]         cand;
  logic [2:0]         next_ptr;
  logic [NUM_REQ-1:0] ack_vec;

  // Two-flop synchronisers. Chip select resets to "released" so nothing is
  // granted until the pad has really been seen low for two clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scs_meta_q  <= 1'b1;
      scs_s_q     <= 1'b1;
      done_meta_q <= 1'b0;
      done_s_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      scs_meta_q  <= scs_i;
      scs_s_q     <= scs_meta_q;
      done_meta_q <= tx_done_i;
      done_s_q    <= done_meta_q;
      done_q      <= done_s_q;
    end
  end

  assign done_rise = done_s_q & ~done_q;

  // Round-robin search: first valid requester at or after rr_ptr_q, wrapping.
  // rr_ptr_q < NUM_REQ, so one conditional subtract is enough for the wrap.
  // The inner loop compares against constants to keep all selects static.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!arb_found && (cand == 4'(i)) && req_valid_i[i]) begin
          arb_found = 1'b1;
          arb_idx   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    arb_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == 3'(i)) begin
        arb_data = req_data_i[32*i +: 32];
      end
    end
  end

  // Pointer moves past the requester just served; decoded ack for grant_o.
  always_comb begin
    next_ptr = (grant_o == 3'(NUM_REQ - 1)) ? 3'd0 : grant_o + 3'd1;
    ack_vec  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      ack_vec[i] = (grant_o == 3'(i));
    end
  end

  // Scheduler FSM with registered outputs. Chip select release is checked
  // before done_rise so that a simultaneous pair retries the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      req_ack_o  <= '0;
      grant_o    <= '0;
      abort_o    <= 1'b0;
      rr_ptr_q   <= '0;
      load_cnt_q <= '0;
    end else begin
      req_ack_o <= '0;
      abort_o   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!scs_s_q && arb_found) begin
            state_q    <= StLoad;
            tx_valid_o <= 1'b1;
            tx_data_o  <= arb_data;
            grant_o    <= arb_idx;
            load_cnt_q <= '0;
          end
        end
        StLoad: begin
          load_cnt_q <= load_cnt_q + 4'd1;
          if (scs_s_q) begin
            state_q    <= StIdle;
            tx_valid_o <= 1'b0;
            abort_o    <= 1'b1;
          end else if (load_cnt_q == 4'(LOAD_CYCLES - 1)) begin
            state_q    <= StShift;
            tx_valid_o <= 1'b0;
          end
        end
        StShift: begin
          if (scs_s_q) begin
            state_q <= StIdle;
            abort_o <= 1'b1;
          end else if (done_rise) begin
            state_q   <= StIdle;
            req_ack_o <= ack_vec;
            rr_ptr_q  <= next_ptr;
          end
        end
        default: begin
          state_q    <= StIdle;
          tx_valid_o <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = (state_q != StIdle);

endmodule

// File: doc/spi_tx_scheduler.md
# spi_tx_scheduler

System-clock controller that shares the SPI slave transmit shift path among several on-chip requesters. It round-robin arbitrates 32-bit words and presents each one to the sender's parallel-load port. It then tracks the sender's word-complete flag, brought over from the SPI clock domain, before acknowledging the requester. An abort path retries the word when the SPI master releases chip select mid-word.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, 1..8.
- LOAD_CYCLES, 8: clk cycles that tx_valid_o is held high per word; must exceed one sck period plus 2 clk cycles.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  requester i has a word pending; held until its ack.
- req_data_i  in  32*NUM_REQ  word of requester i at bits [32*i+31:32*i]; stable while req_valid_i[i]=1.
- req_ack_o  out  NUM_REQ  one-cycle pulse: word of requester i fully shifted out.
- scs_i  in  1  SPI chip select from pad, active-low, asynchronous to clk.
- tx_data_o  out  32  word driven to the sender's parallel input.
- tx_valid_o  out  1  load request to the sender.
- tx_done_i  in  1  sender word-complete flag, sck domain.
- busy_o  out  1  state != IDLE.
- grant_o  out  3  index of current or last granted requester.
- abort_o  out  1  one-cycle pulse: word abandoned because chip select deasserted.

## Operation
- scs_i and tx_done_i each pass through a 2-flop synchronizer (reset value: scs_s=1, done_s=0). done_q is the registered done_s; done_rise = done_s & ~done_q.
- States: IDLE, LOAD, SHIFT.
- IDLE: if scs_s=0 and any req_valid_i bit is set:
  - Grant the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch its data into tx_data_o and its index into grant_o.
  - Go to LOAD.
- LOAD: tx_valid_o=1. A 4-bit counter loads 0 and increments each cycle. After LOAD_CYCLES cycles in LOAD, go to SHIFT with tx_valid_o=0.
- SHIFT: wait for done_rise. On done_rise:
  - Pulse req_ack_o[grant_o].
  - Set rr_ptr = (grant_o+1) mod NUM_REQ.
  - Return to IDLE.
- Abort: scs_s=1 in LOAD or SHIFT causes:
  - tx_valid_o=0, pulse abort_o, return to IDLE.
  - No ack; rr_ptr unchanged, so the same requester is regranted first.
- A done_rise outside SHIFT is ignored.
- tx_data_o holds its value after completion or abort until the next grant.
- Requester deasserting req_valid_i while granted: not allowed; the word is still sent and acked.
- Reset values: state IDLE, tx_valid_o=0, tx_data_o=0, req_ack_o=0, busy_o=0, grant_o=0, abort_o=0, rr_ptr=0, load counter=0.
- Asynchronous reset in any state returns all registers to these values immediately; no ack or abort pulse is generated.

## Timing
- Grant: requests sampled in IDLE at cycle N; tx_valid_o and the new tx_data_o are registered at N+1. busy_o=1 from N+1.
- tx_valid_o is high for exactly LOAD_CYCLES consecutive cycles.
- Ack latency: req_ack_o pulses in the cycle after done_rise is detected, which is 3 clk cycles after tx_done_i rises (2 sync stages + edge register).
- State is IDLE in the same cycle as the ack. A new grant can occur at the next edge, so the minimum gap between words is 1 IDLE cycle.
- Abort: abort_o pulses 2–3 cycles after scs_i rises. tx_valid_o is low in that same cycle.
- Only one of req_ack_o or abort_o pulses per grant. If done_rise and scs_s=1 arrive in the same SHIFT cycle, abort wins and the word is retried.
- Arbitration is combinational from req_valid_i and rr_ptr and registered at the grant edge. Each ack contains at most one set bit.

## Test plan
- Single word: NUM_REQ=2, req 0 sends 0xA5A5_0F0F with scs low. Required: tx_valid_o high for 8 cycles, then 32 bits shifted MSB-first. req_ack_o=01 pulses once, 3 cycles after tx_done_i rises, and busy_o falls.
- Fairness: req 0 and req 1 both valid continuously with words 0x1111_1111 and 0x2222_2222. Required: grant_o sequence 0,1,0,1. Both requesters get equal ack counts over 8 words.
- Abort: raise scs_i after 10 sck edges while req 1 is in SHIFT. Required: abort_o pulses once and there is no ack. After scs lowers, req 1 is regranted before req 0 and its word is shifted in full.
- Chip select idle: scs_i high with req_valid_i=11. Required: busy_o stays 0 and tx_valid_o stays 0. Grant occurs 3 cycles after scs_i falls.
- Reset mid-LOAD: assert rst_n=0 on the 4th LOAD cycle. Required: all outputs return to reset values in that cycle. After release, the pending request is regranted starting from requester 0.
- Spurious done: pulse tx_done_i while in IDLE or LOAD. Required: no ack, and the state sequence is unaffected.
